// File: rtl/oddr_pattern_sequencer.sv
// Serialises a configured pattern word into D1/D2 bit pairs for an ODDR, in bursts or continuously.
// Latency: first pair on oddr_d1/oddr_d2 two clocks after enable is sampled in IDLE; one pair per clock.
// Backpressure: none; enable is only re-evaluated at word boundaries, so a word is never truncated.
module oddr_pattern_sequencer #(
  parameter int PATTERN_W = 16,
  parameter int CNT_W     = 8,
  parameter int GAP_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [PATTERN_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0]     cfg_repeat,
  input  logic [GAP_W-1:0]     cfg_gap,
  input  logic                 cfg_idle_level,
  output logic                 oddr_d1,
  output logic                 oddr_d2,
  output logic                 oddr_ce,
  output logic                 busy,
  output logic                 word_done,
  output logic                 burst_done,
  output logic [CNT_W-1:0]     words_sent
);

  localparam int PAIRS = PATTERN_W / 2;
  localparam int PC_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_HOLD
  } state_t;

  state_t               state;
  logic [PATTERN_W-1:0] sr;
  logic [PATTERN_W-1:0] pat_q;
  logic [CNT_W-1:0]     rep_q;
  logic [GAP_W-1:0]     gap_q;
  logic                 idle_q;
  logic [PC_W-1:0]      pair_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 stop_req;
  logic [CNT_W-1:0]     ws_inc;

  assign ws_inc = words_sent + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sr         <= '0;
      pat_q      <= '0;
      rep_q      <= '0;
      gap_q      <= '0;
      idle_q     <= 1'b0;
      pair_cnt   <= '0;
      gap_cnt    <= '0;
      stop_req   <= 1'b0;
      oddr_d1    <= 1'b0;
      oddr_d2    <= 1'b0;
      oddr_ce    <= 1'b0;
      busy       <= 1'b0;
      word_done  <= 1'b0;
      burst_done <= 1'b0;
      words_sent <= '0;
    end else begin
      oddr_ce    <= 1'b1;
      word_done  <= 1'b0;
      burst_done <= 1'b0;
      case (state)
        S_IDLE: begin
          oddr_d1 <= cfg_idle_level;
          oddr_d2 <= cfg_idle_level;
          busy    <= enable;
          if (enable) state <= S_LOAD;
        end
        S_LOAD: begin
          pat_q      <= cfg_pattern;
          sr         <= cfg_pattern;
          rep_q      <= cfg_repeat;
          gap_q      <= cfg_gap;
          idle_q     <= cfg_idle_level;
          oddr_d1    <= cfg_idle_level;
          oddr_d2    <= cfg_idle_level;
          words_sent <= '0;
          pair_cnt   <= '0;
          busy       <= 1'b1;
          state      <= S_SHIFT;
        end
        S_SHIFT: begin
          oddr_d1 <= sr[PATTERN_W-1];
          oddr_d2 <= sr[PATTERN_W-2];
          sr      <= sr << 2;
          if (pair_cnt == PC_LAST) begin
            // End-of-word decision: burst count, then enable, then gap length.
            pair_cnt   <= '0;
            word_done  <= 1'b1;
            words_sent <= ws_inc;
            if (rep_q != '0 && ws_inc == rep_q) begin
              burst_done <= 1'b1;
              busy       <= 1'b0;
              state      <= S_HOLD;
            end else if (!enable) begin
              burst_done <= 1'b1;
              busy       <= 1'b0;
              state      <= S_IDLE;
            end else if (gap_q == '0) begin
              sr <= pat_q;
            end else begin
              gap_cnt  <= '0;
              stop_req <= 1'b0;
              state    <= S_GAP;
            end
          end else begin
            pair_cnt <= pair_cnt + PC_W'(1);
          end
        end
        S_GAP: begin
          oddr_d1 <= idle_q;
          oddr_d2 <= idle_q;
          if (!enable) stop_req <= 1'b1;
          if (gap_cnt == gap_q - GAP_W'(1)) begin
            if (stop_req || !enable) begin
              burst_done <= 1'b1;
              busy       <= 1'b0;
              state      <= S_IDLE;
            end else begin
              sr    <= pat_q;
              state <= S_SHIFT;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        S_HOLD: begin
          oddr_d1 <= idle_q;
          oddr_d2 <= idle_q;
          busy    <= 1'b0;
          if (!enable) state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oddr_pattern_sequencer.sv
// Bench for oddr_pattern_sequencer: word-level reference model feeding a scoreboard checked on word_done/burst_done.
module tb_oddr_pattern_sequencer;

  localparam int PW    = 16;
  localparam int CW    = 8;
  localparam int GW    = 8;
  localparam int PAIRS = PW / 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] cfg_pattern = '0;
  logic [CW-1:0] cfg_repeat = '0;
  logic [GW-1:0] cfg_gap = '0;
  logic          cfg_idle_level = 1'b0;
  logic          oddr_d1, oddr_d2, oddr_ce, busy, word_done, burst_done;
  logic [CW-1:0] words_sent;

  oddr_pattern_sequencer #(.PATTERN_W(PW), .CNT_W(CW), .GAP_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_pattern(cfg_pattern), .cfg_repeat(cfg_repeat), .cfg_gap(cfg_gap),
    .cfg_idle_level(cfg_idle_level),
    .oddr_d1(oddr_d1), .oddr_d2(oddr_d2), .oddr_ce(oddr_ce), .busy(busy),
    .word_done(word_done), .burst_done(burst_done), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected word: pattern, idle clocks preceding its data (since LOAD or previous word), level, counter, burst end.
  typedef struct {
    logic [PW-1:0] pat;
    int            lead;
    logic          idle;
    logic [CW-1:0] ws;
    bit            last;
  } exp_word_t;

  exp_word_t     word_q[$];
  logic [CW-1:0] burst_q[$];

  task automatic push_expect(input logic [PW-1:0] pat, input logic [GW-1:0] gap, input logic idle,
                             input int n_words, input bit end_on_word);
    exp_word_t e;
    for (int k = 1; k <= n_words; k++) begin
      e.pat  = pat;
      e.lead = (k == 1) ? 1 : int'(gap);
      e.idle = idle;
      e.ws   = CW'(k);
      e.last = end_on_word && (k == n_words);
      word_q.push_back(e);
    end
    burst_q.push_back(CW'(n_words));
  endtask

  // Monitor: collects presented pairs and scores them against the queues on each pulse.
  logic [1:0] hist[$];
  bit         prev_busy = 1'b0;

  always @(negedge clk) begin : monitor
    exp_word_t     e;
    logic [PW-1:0] wd;
    bit            ok;
    int            lead_n;
    if (!rst_n) begin
      hist.delete();
      prev_busy = 1'b0;
    end else begin
      hist.push_back({oddr_d1, oddr_d2});
      if (busy && !prev_busy) hist.delete();
      if (word_done) begin
        if (word_q.size() == 0) begin
          chk("unexpected_word_done", word_done, 0);
        end else begin
          e = word_q.pop_front();
          chk("word_cycles", hist.size(), e.lead + PAIRS);
          if (hist.size() >= PAIRS) begin
            lead_n = hist.size() - PAIRS;
            ok = 1'b1;
            wd = '0;
            for (int i = 0; i < lead_n; i++)
              if (hist[i] !== {e.idle, e.idle}) ok = 1'b0;
            for (int i = 0; i < PAIRS; i++)
              wd = {wd[PW-3:0], hist[lead_n + i]};
            chk("gap_idle_level", ok, 1);
            chk("word_data", wd, e.pat);
          end
          chk("words_sent", words_sent, e.ws);
          chk("burst_done_with_word", burst_done, e.last);
          chk("busy_at_word_done", busy, !e.last);
        end
        hist.delete();
      end
      if (burst_done) begin
        if (burst_q.size() == 0) chk("unexpected_burst_done", burst_done, 0);
        else chk("burst_words_sent", words_sent, burst_q.pop_front());
        chk("busy_after_burst", busy, 0);
      end
      prev_busy = busy;
    end
  end

  task automatic wait_words(input int n, input int limit);
    int seen = 0;
    for (int t = 0; t < limit && seen < n; t++) begin
      @(negedge clk);
      if (word_done === 1'b1) seen++;
    end
    chk("word_done_count", seen, n);
  endtask

  task automatic wait_burst(input int limit);
    bit seen = 1'b0;
    for (int t = 0; t < limit && !seen; t++) begin
      @(negedge clk);
      seen = (burst_done === 1'b1);
    end
    chk("burst_done_seen", seen, 1);
  endtask

  task automatic run_burst(input logic [PW-1:0] pat, input logic [CW-1:0] rep, input logic [GW-1:0] gap,
                           input logic idle, input int n_cont, input bit abort_gap);
    int n_words;
    bit ok;
    n_words = (rep != '0) ? int'(rep) : n_cont;
    @(negedge clk);
    cfg_pattern    = pat;
    cfg_repeat     = rep;
    cfg_gap        = gap;
    cfg_idle_level = idle;
    push_expect(pat, gap, idle, n_words, !abort_gap);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    // Shadow registers are loaded by now; later config changes must not leak out.
    cfg_pattern    = 16'hFFFF;
    cfg_repeat     = CW'($urandom);
    cfg_gap        = GW'($urandom);
    cfg_idle_level = 1'($urandom);
    if (rep == '0) begin
      if (abort_gap) begin
        wait_words(n_words, n_words * (PAIRS + int'(gap) + 2) + 20);
      end else begin
        wait_words(n_words - 1, n_words * (PAIRS + int'(gap) + 2) + 20);
        repeat (((n_words == 1) ? 0 : int'(gap)) + 3) @(negedge clk);
      end
      enable = 1'b0;
    end
    wait_burst(n_words * (PAIRS + int'(gap) + 2) + 20);
    if (rep != '0) begin
      ok = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (busy !== 1'b0 || words_sent !== rep || oddr_d1 !== idle || oddr_d2 !== idle || word_done !== 1'b0)
          ok = 1'b0;
      end
      chk("hold_until_enable_low", ok, 1);
      enable = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    bit ok;
    // Reset and release with enable low, idle level high.
    cfg_idle_level = 1'b1;
    cfg_pattern    = 16'hA5C3;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {oddr_d1, oddr_d2, oddr_ce, busy, word_done, burst_done, words_sent}, 0);
    #2 rst_n = 1'b1;
    #1 chk("ce_before_first_edge", oddr_ce, 0);
    @(posedge clk);
    #1 chk("ce_after_release", oddr_ce, 1);
    chk("idle_level_after_release", {oddr_d1, oddr_d2}, 2'b11);
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0 || {oddr_d1, oddr_d2} !== 2'b11) ok = 1'b0;
    end
    chk("idle_not_busy", ok, 1);

    run_burst(16'hA5C3, 8'd1, 8'd0, 1'b0, 0, 1'b0);
    run_burst(16'hA5C3, 8'd3, 8'd2, 1'b1, 0, 1'b0);
    run_burst(16'hA5C3, 8'd0, 8'd0, 1'b0, 5, 1'b0);
    run_burst(16'hA5C3, 8'd2, 8'd0, 1'b0, 0, 1'b0);
    run_burst(PW'($urandom), 8'd0, 8'd4, 1'b1, 2, 1'b1);

    // Asynchronous reset while pair 4 of a word is on the outputs.
    @(negedge clk);
    cfg_pattern    = 16'hA5C3;
    cfg_repeat     = 8'd1;
    cfg_gap        = 8'd0;
    cfg_idle_level = 1'b0;
    enable         = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    word_q.delete();
    burst_q.delete();
    #1 chk("async_reset_outputs", {oddr_d1, oddr_d2, oddr_ce, busy, word_done, burst_done, words_sent}, 0);
    push_expect(16'hA5C3, 8'd0, 1'b0, 1, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("ce_low_until_edge", oddr_ce, 0);
    wait_burst(40);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_burst(PW'($urandom), CW'($urandom_range(0, 4)), GW'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), int'($urandom_range(1, 4)), 1'b0);

    // Continuous run long enough to wrap words_sent.
    run_burst(PW'($urandom), 8'd0, 8'd0, 1'b1, 257, 1'b0);

    chk("word_queue_drained", word_q.size(), 0);
    chk("burst_queue_drained", burst_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
